// File: rtl/alu_op_sequencer.sv
// Command sequencer that feeds operands and an operation select to an external ALU.
// It captures the ALU result with status flags and counts completed legal operations.
module alu_op_sequencer #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [3:0]   cmd_op,
    input  logic [N-1:0] cmd_a,
    input  logic [N-1:0] cmd_b,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [3:0]   select_alu,
    input  logic [N-1:0] alu_result,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [N-1:0] rsp_data,
    output logic         rsp_zero,
    output logic         rsp_neg,
    output logic         rsp_ovf,
    output logic         rsp_err,
    output logic [7:0]   op_count
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;

    state_t       state_q, state_d;
    logic [3:0]   op_q, op_d;
    logic [N-1:0] a_q, a_d;
    logic [N-1:0] b_q, b_d;
    logic [N-1:0] data_q, data_d;
    logic         zero_q, zero_d;
    logic         neg_q, neg_d;
    logic         ovf_q, ovf_d;
    logic         err_q, err_d;
    logic [7:0]   count_q, count_d;
    logic         op_legal;
    logic         ovf_calc;

    assign op_legal = (cmd_op[3:2] == 2'b00);

    // Signed overflow is judged from operand and result sign bits only.
    always_comb begin
        ovf_calc = 1'b0;
        case (op_q)
            OP_ADD:  ovf_calc = (a_q[N-1] == b_q[N-1]) && (alu_result[N-1] != a_q[N-1]);
            OP_SUB:  ovf_calc = (a_q[N-1] != b_q[N-1]) && (alu_result[N-1] != a_q[N-1]);
            default: ovf_calc = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        data_d  = data_q;
        zero_d  = zero_q;
        neg_d   = neg_q;
        ovf_d   = ovf_q;
        err_d   = err_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    if (op_legal) begin
                        op_d    = cmd_op;
                        a_d     = cmd_a;
                        b_d     = cmd_b;
                        state_d = EXEC;
                    end else begin
                        // Illegal opcodes bypass EXEC so select_alu never sees them.
                        data_d  = '0;
                        zero_d  = 1'b0;
                        neg_d   = 1'b0;
                        ovf_d   = 1'b0;
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            EXEC: begin
                data_d  = alu_result;
                zero_d  = (alu_result == '0);
                neg_d   = alu_result[N-1];
                ovf_d   = ovf_calc;
                err_d   = 1'b0;
                count_d = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            data_q  <= '0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            data_q  <= data_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
            count_q <= count_d;
        end
    end

    assign cmd_ready  = (state_q == IDLE);
    assign rsp_valid  = (state_q == RESP);
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign select_alu = op_q;
    assign rsp_data   = data_q;
    assign rsp_zero   = zero_q;
    assign rsp_neg    = neg_q;
    assign rsp_ovf    = ovf_q;
    assign rsp_err    = err_q;
    assign op_count   = count_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: directed table, stall, mid-operation
// reset, randomized traffic against an arithmetic reference model, and count saturation.
module tb_alu_op_sequencer;

    localparam int N    = 4;
    localparam int FULL = 1 << N;
    localparam int HALF = 1 << (N - 1);

    logic         clk;
    logic         rst_n;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [3:0]   cmd_op;
    logic [N-1:0] cmd_a;
    logic [N-1:0] cmd_b;
    logic [N-1:0] alu_a;
    logic [N-1:0] alu_b;
    logic [3:0]   select_alu;
    logic [N-1:0] alu_result;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [N-1:0] rsp_data;
    logic         rsp_zero;
    logic         rsp_neg;
    logic         rsp_ovf;
    logic         rsp_err;
    logic [7:0]   op_count;

    int vectors;
    int miscompares;
    int expCount;
    int expSel;
    int expA;
    int expB;

    typedef struct {
        logic [3:0]   op;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] data;
        logic         zero;
        logic         neg;
        logic         ovf;
        logic         err;
    } vec_t;

    vec_t tbl[10];

    alu_op_sequencer #(.N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .select_alu (select_alu),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_zero   (rsp_zero),
        .rsp_neg    (rsp_neg),
        .rsp_ovf    (rsp_ovf),
        .rsp_err    (rsp_err),
        .op_count   (op_count)
    );

    // External ALU datapath model, combinational from the sequencer's drive.
    always_comb begin
        alu_result = '0;
        case (select_alu)
            4'd0:    alu_result = alu_a + alu_b;
            4'd1:    alu_result = alu_a - alu_b;
            4'd2:    alu_result = alu_a & alu_b;
            4'd3:    alu_result = alu_a | alu_b;
            default: alu_result = '0;
        endcase
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference computed from signed integer ranges rather than sign-bit rules.
    function automatic void refModel(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                                     output logic [N-1:0] d, output logic z, output logic ng,
                                     output logic o, output logic e);
        int ua, ub, sa, sb, full, sres, m;
        ua = int'(a);
        ub = int'(b);
        sa = (ua >= HALF) ? ua - FULL : ua;
        sb = (ub >= HALF) ? ub - FULL : ub;
        sres = 0;
        full = 0;
        e = 1'b0;
        case (op)
            4'd0: begin full = ua + ub; sres = sa + sb; end
            4'd1: begin full = ua - ub; sres = sa - sb; end
            4'd2: full = ua & ub;
            4'd3: full = ua | ub;
            default: e = 1'b1;
        endcase
        m  = ((full % FULL) + FULL) % FULL;
        d  = e ? '0 : m[N-1:0];
        o  = !e && (op < 4'd2) && ((sres > HALF - 1) || (sres < -HALF));
        z  = !e && (m == 0);
        ng = !e && (m >= HALF);
    endfunction

    // Runs one full transaction starting and ending at a falling edge, rsp_ready=1.
    task automatic applyStimulus(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                                 input logic [N-1:0] eData, input logic eZ, input logic eN,
                                 input logic eO, input logic eE);
        logic legal;
        legal = (op < 4'd4);
        rsp_ready = 1'b1;
        checkOutput("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = 4'($urandom);
        cmd_a     = N'($urandom);
        cmd_b     = N'($urandom);
        if (legal) begin
            expSel = int'(op);
            expA   = int'(a);
            expB   = int'(b);
            if (expCount < 255) expCount++;
            checkOutput("exec_rsp_valid", rsp_valid, 0);
            checkOutput("exec_cmd_ready", cmd_ready, 0);
            checkOutput("exec_select_alu", select_alu, expSel);
            checkOutput("exec_alu_a", alu_a, expA);
            checkOutput("exec_alu_b", alu_b, expB);
            @(posedge clk);
            @(negedge clk);
        end
        checkOutput("rsp_valid", rsp_valid, 1);
        checkOutput("rsp_cmd_ready", cmd_ready, 0);
        checkOutput("rsp_data", rsp_data, eData);
        checkOutput("rsp_zero", rsp_zero, eZ);
        checkOutput("rsp_neg", rsp_neg, eN);
        checkOutput("rsp_ovf", rsp_ovf, eO);
        checkOutput("rsp_err", rsp_err, eE);
        checkOutput("rsp_op_count", op_count, expCount);
        checkOutput("rsp_select_alu", select_alu, expSel);
        @(posedge clk);
        @(negedge clk);
        checkOutput("after_rsp_valid", rsp_valid, 0);
        checkOutput("after_cmd_ready", cmd_ready, 1);
    endtask

    initial begin
        logic [3:0]   op;
        logic [N-1:0] a, b, d, sd;
        logic         z, ng, o, e, sz, sn, so, se;

        vectors     = 0;
        miscompares = 0;
        expCount    = 0;
        expSel      = 0;
        expA        = 0;
        expB        = 0;

        tbl[0] = '{4'b0000, 4'b0111, 4'b0001, 4'b1000, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[1] = '{4'b0001, 4'b0011, 4'b0011, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{4'b0010, 4'b1100, 4'b1010, 4'b1000, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{4'b0011, 4'b1100, 4'b0011, 4'b1111, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{4'b0111, 4'b0101, 4'b0011, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[5] = '{4'b0001, 4'b1000, 4'b0001, 4'b0111, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[6] = '{4'b0000, 4'b1111, 4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{4'b0000, 4'b1000, 4'b1000, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[8] = '{4'b0001, 4'b0111, 4'b1111, 4'b1000, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[9] = '{4'b1111, 4'b1010, 4'b0101, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1};

        rst_n     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_a     = '0;
        cmd_b     = '0;
        rsp_ready = 1'b1;

        #1 rst_n = 1'b0;
        #1;
        checkOutput("reset_cmd_ready", cmd_ready, 1);
        checkOutput("reset_rsp_valid", rsp_valid, 0);
        checkOutput("reset_op_count", op_count, 0);
        checkOutput("reset_select_alu", select_alu, 0);
        checkOutput("reset_alu_a", alu_a, 0);
        checkOutput("reset_rsp_data", rsp_data, 0);
        checkOutput("reset_rsp_err", rsp_err, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] directed table");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].data,
                          tbl[i].zero, tbl[i].neg, tbl[i].ovf, tbl[i].err);
        end

        $display("[TB] response stall with competing commands");
        rsp_ready = 1'b0;
        refModel(4'd1, 4'b0101, 4'b0010, sd, sz, sn, so, se);
        cmd_valid = 1'b1;
        cmd_op    = 4'd1;
        cmd_a     = 4'b0101;
        cmd_b     = 4'b0010;
        @(posedge clk);
        @(negedge clk);
        expSel = 1;
        expA   = 5;
        expB   = 2;
        if (expCount < 255) expCount++;
        cmd_op = 4'd2;
        cmd_a  = 4'b1111;
        cmd_b  = 4'b1111;
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            checkOutput("stall_rsp_valid", rsp_valid, 1);
            checkOutput("stall_cmd_ready", cmd_ready, 0);
            checkOutput("stall_rsp_data", rsp_data, sd);
            checkOutput("stall_rsp_flags", {rsp_zero, rsp_neg, rsp_ovf, rsp_err}, {sz, sn, so, se});
            checkOutput("stall_select_alu", select_alu, expSel);
            checkOutput("stall_alu_a", alu_a, expA);
            checkOutput("stall_op_count", op_count, expCount);
            cmd_op = 4'($urandom_range(0, 3));
            cmd_a  = N'($urandom);
            cmd_b  = N'($urandom);
            @(posedge clk);
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("stall_release_valid", rsp_valid, 0);
        checkOutput("stall_release_ready", cmd_ready, 1);
        @(posedge clk);
        @(negedge clk);
        checkOutput("stall_no_second_op", rsp_valid, 0);
        checkOutput("stall_count_kept", op_count, expCount);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) op = 4'($urandom_range(4, 15));
            else                           op = 4'($urandom_range(0, 3));
            a = N'($urandom);
            b = N'($urandom);
            refModel(op, a, b, d, z, ng, o, e);
            applyStimulus(op, a, b, d, z, ng, o, e);
        end

        $display("[TB] reset in the middle of an operation");
        cmd_valid = 1'b1;
        cmd_op    = 4'd0;
        cmd_a     = 4'b0011;
        cmd_b     = 4'b0010;
        @(posedge clk);
        #2 rst_n  = 1'b0;
        cmd_valid = 1'b0;
        #1;
        checkOutput("midreset_rsp_valid", rsp_valid, 0);
        checkOutput("midreset_cmd_ready", cmd_ready, 1);
        checkOutput("midreset_op_count", op_count, 0);
        checkOutput("midreset_select_alu", select_alu, 0);
        checkOutput("midreset_alu_a", alu_a, 0);
        checkOutput("midreset_alu_b", alu_b, 0);
        checkOutput("midreset_rsp_data", rsp_data, 0);
        checkOutput("midreset_flags", {rsp_zero, rsp_neg, rsp_ovf, rsp_err}, 0);
        @(negedge clk);
        rst_n    = 1'b1;
        expCount = 0;
        expSel   = 0;
        expA     = 0;
        expB     = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("postreset_no_rsp", rsp_valid, 0);
            checkOutput("postreset_count", op_count, 0);
        end

        $display("[TB] back-to-back legal ops up to saturation");
        for (int i = 0; i < 260; i++) begin
            op = 4'($urandom_range(0, 3));
            a  = N'($urandom);
            b  = N'($urandom);
            refModel(op, a, b, d, z, ng, o, e);
            applyStimulus(op, a, b, d, z, ng, o, e);
        end
        checkOutput("saturated_count", op_count, 255);
        refModel(4'b1001, 4'd3, 4'd4, d, z, ng, o, e);
        applyStimulus(4'b1001, 4'd3, 4'd4, d, z, ng, o, e);
        checkOutput("saturated_after_illegal", op_count, 255);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
